// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Each operation takes one IDLE, one EXEC and one RESP cycle. Operands are
// registered before they reach the ALU, and the result is held in RESP until
// the consumer accepts it.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_eq,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_eq,
  output logic [15:0]      done_cnt
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic             r_last_id;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_c;
  logic             r_rsp_eq;
  logic [15:0]      r_done_cnt;
  logic             w_grant;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_rsp_fire;

  // Grant: a lone requester wins; on a tie, the requester not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_id;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Next state and handshake strobes; ready never depends on rsp_ready.
  always_comb begin
    w_state_d    = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_rsp_fire   = 1'b0;
    case (r_state)
      StIdle: begin
        // Gated with reset so ready stays low while reset is held.
        w_req0_ready = reset && req0_valid && !w_grant;
        w_req1_ready = reset && req1_valid && w_grant;
        if (w_req0_ready || w_req1_ready) begin
          w_state_d = StExec;
        end
      end
      StExec: w_state_d = StResp;
      StResp: begin
        w_rsp_fire = rsp_ready;
        if (rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Operand latch, result capture, round-robin history and completion counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_id       <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_c    <= '0;
      r_rsp_eq   <= 1'b0;
      r_last_id  <= 1'b1;  // requester 0 wins the first tie
      r_done_cnt <= '0;
    end else begin
      if (w_req0_ready) begin
        r_a  <= req0_a;
        r_b  <= req0_b;
        r_op <= req0_op;
        r_id <= 1'b0;
      end else if (w_req1_ready) begin
        r_a  <= req1_a;
        r_b  <= req1_b;
        r_op <= req1_op;
        r_id <= 1'b1;
      end
      if (r_state == StExec) begin
        r_rsp_c  <= alu_c;
        r_rsp_eq <= alu_eq;
        r_rsp_id <= r_id;
      end
      if (w_rsp_fire) begin
        r_last_id <= r_rsp_id;
        if (r_done_cnt != 16'hFFFF) begin
          r_done_cnt <= r_done_cnt + 16'd1;
        end
      end
    end
  end

  assign req0_ready = w_req0_ready;
  assign req1_ready = w_req1_ready;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign rsp_valid  = (r_state == StResp);
  assign rsp_id     = r_rsp_id;
  assign rsp_c      = r_rsp_c;
  assign rsp_eq     = r_rsp_eq;
  assign done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table-driven arbitration rounds, a
// response scoreboard, and hand-written latency/backpressure/reset/saturation
// and contention sequences.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OPW-1:0]   req0_op = '0, req1_op = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic [OPW-1:0]   alu_op;
  logic             alu_eq;
  logic             rsp_valid, rsp_id, rsp_eq;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_c;
  logic [15:0]      done_cnt;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_eq(alu_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .rsp_eq(rsp_eq), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Shared ALU: any opcode is legal, the arbiter must just pass it through.
  function automatic logic [WIDTH-1:0] model_c(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [OPW-1:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb begin
    alu_c  = model_c(alu_a, alu_b, alu_op);
    alu_eq = (alu_a == alu_b);
  end

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] c;
    logic             eq;
  } exp_t;

  typedef struct {
    logic             v0;
    logic [WIDTH-1:0] a0, b0;
    logic [OPW-1:0]   op0;
    logic             v1;
    logic [WIDTH-1:0] a1, b1;
    logic [OPW-1:0]   op1;
    logic             first_id;
  } vec_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_done = '0;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                              input logic [OPW-1:0] op0, input logic v1,
                              input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                              input logic [OPW-1:0] op1, input logic first_id);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.first_id = first_id;
    return v;
  endfunction

  // Monitor: push expectations on each handshake, check responses as they are accepted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (req0_ready || req1_ready) begin
          check("ready_legal", 64'((req0_ready & req1_ready) | (req0_ready & !req0_valid) |
                                   (req1_ready & !req1_valid)), 64'd0);
          if (req0_ready) sb_q.push_back({1'b0, model_c(req0_a, req0_b, req0_op), req0_a == req0_b});
          else            sb_q.push_back({1'b1, model_c(req1_a, req1_b, req1_op), req1_a == req1_b});
        end
        if (rsp_valid) check("no_ready_in_resp", 64'(req0_ready | req1_ready), 64'd0);
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_c", 64'(rsp_c), 64'(e.c));
            check("rsp_eq", 64'(rsp_eq), 64'(e.eq));
          end
          check("done_cnt_pre", 64'(done_cnt), 64'(exp_done));
          if (exp_done != 16'hFFFF) exp_done = exp_done + 16'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb_q.delete();
    exp_done = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    tick();
  endtask

  // Present a round's requests; drop each valid after its handshake; check the first grant.
  task automatic serve_round(input vec_t v);
    int   n = 0;
    logic first = 1'b1;
    logic got;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    while ((req0_valid || req1_valid) && n < 50) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) begin
        got = req1_ready;
        if (first) check("first_grant", 64'(got), 64'(v.first_id));
        first = 1'b0;
        tick();
        if (got) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
      end
    end
    check("round_served", 64'(req0_valid | req1_valid), 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain(20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] bp_c;
    int               hs;
    int               n;
    logic             exp_id;
    logic             got;

    vecs[0] = mk(1, 3, 3, 0, 1, 1, 2, 0, 1'b0);
    vecs[1] = mk(1, 10, 4, 1, 1, 8, 8, 2, 1'b0);
    vecs[2] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 1'b1);
    vecs[3] = mk(1, 7, 7, 3, 0, 0, 0, 0, 1'b0);
    vecs[4] = mk(1, 1, 1, 4, 1, 2, 3, 5, 1'b1);
    vecs[5] = mk(1, 6, 9, 6, 1, 12, 5, 7, 1'b1);

    // Reset values, with a request pending to show ready is held low.
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_req1_ready", 64'(req1_ready), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_c", 64'(rsp_c), 64'd0);
    check("rst_rsp_eq", 64'(rsp_eq), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    reset = 1'b1;

    // Single request latency: response two cycles after the handshake.
    req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'd0;
    @(negedge clk);
    check("single_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("single_exec_no_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_id", 64'(rsp_id), 64'd0);
    check("single_rsp_c", 64'(rsp_c), 64'd12);
    check("single_rsp_eq", 64'(rsp_eq), 64'd0);
    tick();
    check("single_done", 64'(done_cnt), 64'd1);
    tick();

    // Table of arbitration rounds starting from a fresh reset.
    do_reset();
    for (int i = 0; i < 6; i++) serve_round(vecs[i]);
    check("table_done", 64'(done_cnt), 64'd10);

    // Backpressure, with requester 1 arriving during EXEC and RESP.
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd22; req0_op = 3'd1;
    bp_c = 32'hFFFF_FFFE;
    @(negedge clk);
    check("bp_grant", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'd0;
    @(negedge clk);
    check("bp_exec_no_ready", 64'(req1_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_id", 64'(rsp_id), 64'd0);
      check("bp_rsp_c", 64'(rsp_c), 64'(bp_c));
      check("bp_rsp_eq", 64'(rsp_eq), 64'd0);
      check("bp_no_ready", 64'(req0_ready | req1_ready), 64'd0);
      check("bp_done_held", 64'(done_cnt), 64'd10);
    end
    tick();
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    wait_drain(20);
    check("bp_done", 64'(done_cnt), 64'd11);

    // Reset during EXEC aborts the operation asynchronously.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd0;
    @(negedge clk);
    check("mid_grant", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    reset = 1'b0;
    sb_q.delete();
    exp_done = '0;
    #1;
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_alu_a", 64'(alu_a), 64'd0);
    check("mid_alu_b", 64'(alu_b), 64'd0);
    check("mid_rsp_c", 64'(rsp_c), 64'd0);
    check("mid_done_cnt", 64'(done_cnt), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    tick();
    reset = 1'b1;
    serve_round(mk(0, 0, 0, 0, 1, 4, 4, 2, 1'b1));
    check("mid_after_done", 64'(done_cnt), 64'd1);

    // Saturation: preload near the top, then complete three more ops.
    @(negedge clk);
    force dut.r_done_cnt = 16'hFFFD;
    exp_done = 16'hFFFD;
    tick();
    release dut.r_done_cnt;
    check("sat_preload", 64'(done_cnt), 64'hFFFD);
    serve_round(mk(1, 2, 2, 0, 0, 0, 0, 0, 1'b0));
    check("sat_fffe", 64'(done_cnt), 64'hFFFE);
    serve_round(mk(1, 3, 2, 0, 0, 0, 0, 0, 1'b0));
    check("sat_ffff", 64'(done_cnt), 64'hFFFF);
    serve_round(mk(1, 4, 2, 0, 0, 0, 0, 0, 1'b0));
    check("sat_hold", 64'(done_cnt), 64'hFFFF);

    // Sustained contention: grants must alternate, starting with requester 1.
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = OPW'($urandom_range(0, 7));
    req1_valid = 1'b1; req1_a = $urandom; req1_b = req1_a;   req1_op = OPW'($urandom_range(0, 7));
    exp_id = 1'b1;
    hs = 0;
    n  = 0;
    while (hs < 20 && n < 200) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) begin
        got = req1_ready;
        check("alt_grant", 64'(got), 64'(exp_id));
        exp_id = ~exp_id;
        hs++;
        tick();
        if (hs == 20) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end else if (got) begin
          req1_a = $urandom; req1_b = $urandom; req1_op = OPW'($urandom_range(0, 7));
        end else begin
          req0_a = $urandom; req0_b = $urandom; req0_op = OPW'($urandom_range(0, 7));
        end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("alt_count", 64'(hs), 64'd20);
    wait_drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
